// File: rtl/tmr_vote_monitor.sv
// Triplicated-bus receiver: bitwise majority vote, lane mismatch counters and req/ack event reporting.
// Optional per-lane scrub pulses are built only when TMR_MON_SCRUB_EN is defined.
module tmr_vote_monitor #(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 8,
   parameter int PERSIST = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   input  logic             clr,
   output logic [WIDTH-1:0] out,
   output logic             err_a,
   output logic             err_b,
   output logic             err_c,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_c,
   output logic             evt_req,
   input  logic             evt_ack,
   output logic [1:0]       evt_lane,
   output logic             evt_multi,
   output logic             evt_ovf
`ifdef TMR_MON_SCRUB_EN
   ,
   output logic             scrub_a,
   output logic             scrub_b,
   output logic             scrub_c
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] vote_s;
   logic             mis_a_s, mis_b_s, mis_c_s, any_s, multi_s;

   logic [WIDTH-1:0] out_q;
   logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_c_q;
   logic [CNT_W-1:0] cnt_a_d, cnt_b_d, cnt_c_d;
   logic             err_a_q, err_b_q, err_c_q;
   logic [1:0]       state_q, state_d;
   logic             req_q, req_d, multi_q, multi_d, ovf_q, ovf_d;
   logic [1:0]       lane_q, lane_d;

   // Saturating counter step; clr takes priority over a simultaneous mismatch.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic mis, input logic clear);
      if (clear)
         cnt_next = '0;
      else if (mis && (cnt != CNT_MAX))
         cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      else
         cnt_next = cnt;
   endfunction

   assign vote_s  = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
   assign mis_a_s = |(in_a ^ vote_s);
   assign mis_b_s = |(in_b ^ vote_s);
   assign mis_c_s = |(in_c ^ vote_s);
   assign any_s   = mis_a_s | mis_b_s | mis_c_s;
   assign multi_s = (mis_a_s & mis_b_s) | (mis_a_s & mis_c_s) | (mis_b_s & mis_c_s);

   assign cnt_a_d = cnt_next(cnt_a_q, mis_a_s, clr);
   assign cnt_b_d = cnt_next(cnt_b_q, mis_b_s, clr);
   assign cnt_c_d = cnt_next(cnt_c_q, mis_c_s, clr);
   assign ovf_d   = clr ? 1'b0 : (ovf_q | (any_s & (state_q != ST_IDLE)));

   // Event handshake next-state: capture in IDLE, hold through REQ, wait for ack release in DROP.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      lane_d  = lane_q;
      multi_d = multi_q;
      case (state_q)
         ST_IDLE: begin
            if (any_s) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               multi_d = multi_s;
               lane_d  = mis_a_s ? 2'd1 : (mis_b_s ? 2'd2 : 2'd3);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (evt_ack) begin
               req_d   = 1'b0;
               state_d = ST_DROP;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DROP: begin
            if (!evt_ack)
               state_d = ST_IDLE;
            else
               state_d = ST_DROP;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // Output, counter, flag and FSM registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q   <= '0;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         cnt_c_q <= '0;
         err_a_q <= 1'b0;
         err_b_q <= 1'b0;
         err_c_q <= 1'b0;
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         lane_q  <= 2'd0;
         multi_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         out_q   <= vote_s;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         cnt_c_q <= cnt_c_d;
         err_a_q <= clr ? 1'b0 : (err_a_q | mis_a_s);
         err_b_q <= clr ? 1'b0 : (err_b_q | mis_b_s);
         err_c_q <= clr ? 1'b0 : (err_c_q | mis_c_s);
         state_q <= state_d;
         req_q   <= req_d;
         lane_q  <= lane_d;
         multi_q <= multi_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out       = out_q;
   assign cnt_a     = cnt_a_q;
   assign cnt_b     = cnt_b_q;
   assign cnt_c     = cnt_c_q;
   assign err_a     = err_a_q;
   assign err_b     = err_b_q;
   assign err_c     = err_c_q;
   assign evt_req   = req_q;
   assign evt_lane  = lane_q;
   assign evt_multi = multi_q;
   assign evt_ovf   = ovf_q;

`ifdef TMR_MON_SCRUB_EN
   logic [2:0]      mis_vec_s;
   logic [2:0][7:0] pers_q, pers_d;
   logic [2:0]      scrub_q, scrub_d;

   assign mis_vec_s = {mis_c_s, mis_b_s, mis_a_s};

   // Persistence run per lane; the pulse fires on the PERSIST-th consecutive mismatch and restarts the run.
   always_comb begin
      pers_d  = pers_q;
      scrub_d = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (clr || !mis_vec_s[i]) begin
            pers_d[i]  = 8'd0;
            scrub_d[i] = 1'b0;
         end else if (pers_q[i] == 8'(PERSIST - 1)) begin
            pers_d[i]  = 8'd0;
            scrub_d[i] = 1'b1;
         end else begin
            pers_d[i]  = pers_q[i] + 8'd1;
            scrub_d[i] = 1'b0;
         end
      end
   end

   // Persistence and scrub pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pers_q  <= '0;
         scrub_q <= 3'b000;
      end else begin
         pers_q  <= pers_d;
         scrub_q <= scrub_d;
      end
   end

   assign scrub_a = scrub_q[0];
   assign scrub_b = scrub_q[1];
   assign scrub_c = scrub_q[2];
`endif

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Self-checking bench for tmr_vote_monitor: directed test-plan steps plus randomized upsets against a reference model.
module tb_tmr_vote_monitor;
   localparam int WIDTH   = 8;
   localparam int CNT_W   = 8;
   localparam int PERSIST = 3;

   logic             clk = 1'b0;
   logic             rst_n, clr, evt_ack;
   logic [WIDTH-1:0] in_a, in_b, in_c, out;
   logic             err_a, err_b, err_c, evt_req, evt_multi, evt_ovf;
   logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;
   logic [1:0]       evt_lane;
`ifdef TMR_MON_SCRUB_EN
   logic             scrub_a, scrub_b, scrub_c;
`endif

   tmr_vote_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PERSIST(PERSIST)) dut (
      .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_c(in_c), .clr(clr),
      .out(out), .err_a(err_a), .err_b(err_b), .err_c(err_c),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c),
      .evt_req(evt_req), .evt_ack(evt_ack), .evt_lane(evt_lane),
      .evt_multi(evt_multi), .evt_ovf(evt_ovf)
`ifdef TMR_MON_SCRUB_EN
      , .scrub_a(scrub_a), .scrub_b(scrub_b), .scrub_c(scrub_c)
`endif
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state, described in terms of observable behaviour.
   logic [WIDTH-1:0] m_out;
   int  m_cnt[3];
   bit  m_err[3];
   bit  m_pending, m_draining;
   int  m_lane;
   bit  m_multi, m_ovf;
   int  m_run[3];
   bit  m_scrub[3];

   function automatic logic [WIDTH-1:0] ref_vote(input logic [WIDTH-1:0] a, b, c);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         int ones;
         ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
         r[i] = (ones >= 2);
      end
      return r;
   endfunction

   task automatic model_step();
      logic [WIDTH-1:0] v;
      bit mis[3];
      int nmis;
      bit busy;
      v = ref_vote(in_a, in_b, in_c);
      mis[0] = (in_a != v);
      mis[1] = (in_b != v);
      mis[2] = (in_c != v);
      nmis = int'(mis[0]) + int'(mis[1]) + int'(mis[2]);
      if (!rst_n) begin
         m_out = '0; m_pending = 0; m_draining = 0; m_lane = 0; m_multi = 0; m_ovf = 0;
         for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_err[i] = 0; m_run[i] = 0; m_scrub[i] = 0;
         end
      end else begin
         m_out = v;
         for (int i = 0; i < 3; i++) begin
            if (clr) begin
               m_cnt[i] = 0; m_err[i] = 0; m_run[i] = 0; m_scrub[i] = 0;
            end else if (mis[i]) begin
               m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
               m_err[i] = 1;
               m_run[i] = m_run[i] + 1;
               m_scrub[i] = (m_run[i] % PERSIST) == 0;
            end else begin
               m_run[i] = 0; m_scrub[i] = 0;
            end
         end
         busy = m_pending || m_draining;
         if (clr) m_ovf = 0;
         else if (nmis > 0 && busy) m_ovf = 1;
         if (m_pending) begin
            if (evt_ack) begin m_pending = 0; m_draining = 1; end
         end else if (m_draining) begin
            if (!evt_ack) m_draining = 0;
         end else if (nmis > 0) begin
            m_pending = 1;
            m_lane = mis[0] ? 1 : (mis[1] ? 2 : 3);
            m_multi = (nmis >= 2);
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("out", 32'(out), 32'(m_out));
      check("err_a", 32'(err_a), 32'(m_err[0]));
      check("err_b", 32'(err_b), 32'(m_err[1]));
      check("err_c", 32'(err_c), 32'(m_err[2]));
      check("cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
      check("cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
      check("cnt_c", 32'(cnt_c), 32'(m_cnt[2]));
      check("evt_req", 32'(evt_req), 32'(m_pending));
      check("evt_lane", 32'(evt_lane), 32'(m_lane));
      check("evt_multi", 32'(evt_multi), 32'(m_multi));
      check("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
`ifdef TMR_MON_SCRUB_EN
      check("scrub_a", 32'(scrub_a), 32'(m_scrub[0]));
      check("scrub_b", 32'(scrub_b), 32'(m_scrub[1]));
      check("scrub_c", 32'(scrub_c), 32'(m_scrub[2]));
`endif
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic handshake();
      evt_ack = 1'b1;
      tick();
      evt_ack = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; evt_ack = 1'b0;
      in_a = 8'hA5; in_b = 8'hA5; in_c = 8'hA5;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("reset_out", 32'(out), 32'h0000_00A5);
      tick();

      // single upset on lane B
      in_b = 8'hA4;
      tick();
      check("single_cnt_b", 32'(cnt_b), 32'd1);
      check("single_lane", 32'(evt_lane), 32'd2);
      check("single_out", 32'(out), 32'h0000_00A5);
      in_b = 8'hA5;
      tick();
      handshake();
      check("single_req_drop", 32'(evt_req), 32'd0);

      // lanes disagree on different bits
      in_a = 8'h01; in_b = 8'h02; in_c = 8'h00;
      tick();
      check("multi_out", 32'(out), 32'd0);
      check("multi_flag", 32'(evt_multi), 32'd1);
      check("multi_lane", 32'(evt_lane), 32'd1);
      in_a = 8'hA5; in_b = 8'hA5; in_c = 8'hA5;
      handshake();

      // long lane C fault with no ack: saturation and overflow
      in_c = 8'h5A;
      repeat (300) tick();
      check("sat_cnt_c", 32'(cnt_c), 32'd255);
      check("sat_ovf", 32'(evt_ovf), 32'd1);
      check("sat_lane", 32'(evt_lane), 32'd3);
      in_c = 8'hA5;
      handshake();

      // clr collides with a lane A mismatch
      clr = 1'b1; in_a = 8'hA4;
      tick();
      check("clr_cnt_a", 32'(cnt_a), 32'd0);
      check("clr_ovf", 32'(evt_ovf), 32'd0);
      check("clr_req", 32'(evt_req), 32'd1);
      clr = 1'b0; in_a = 8'hA5;
      handshake();

`ifdef TMR_MON_SCRUB_EN
      in_a = 8'hA4;
      repeat (7) tick();
      in_a = 8'hA5;
      handshake();
`endif

      // randomized single-bit upsets, random ack and occasional clr
      repeat (500) begin
         logic [WIDTH-1:0] base;
         base = 8'($urandom);
         in_a = base ^ (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
         in_b = base ^ (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
         in_c = base ^ (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
         evt_ack = 1'($urandom);
         clr = ($urandom_range(0, 19) == 0);
         tick();
      end

      // reset in the middle of a request
      clr = 1'b0; in_a = 8'hA5; in_b = 8'hA5; in_c = 8'hA5;
      handshake();
      in_b = 8'h00;
      tick();
      check("mid_req_up", 32'(evt_req), 32'd1);
      in_b = 8'hA5;
      tick();
      rst_n = 1'b0;
      tick();
      check("mid_req_reset", 32'(evt_req), 32'd0);
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
